// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the oversampling UART receiver
// and its receive FIFO.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam int ERR_OVR  = 0;
    localparam int ERR_PERR = 1;
    localparam int ERR_FERR = 2;
    localparam int ERR_BRK  = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_e;

endpackage

// File: rtl/rx_fifo.sv
// Synchronous FIFO with first-word fall-through head, occupancy count and
// full/empty flags; reads as zero while empty.
module rx_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = empty ? '0 : mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling serial receiver: synchronises the line, recovers frames with
// a tick-counting FSM and queues {brk,ferr,perr,data} words for the host.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int OS          = 16,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1,
    parameter int DEPTH       = 4
) (
    input  logic                       overSampler,
    input  logic                       reset_n,
    input  logic                       dataIn,
    input  logic                       host_acknowledged,
    output logic [DATA_W-1:0]          dataOut,
    output logic [3:0]                 err,
    output logic                       host_interrupt,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
    localparam int CNT_W  = $clog2(OS);
    localparam int IDX_W  = $clog2(DATA_W + 1);
    localparam int FC_W   = $clog2(DEPTH + 1);
    localparam int WORD_W = DATA_W + 3;

    rx_state_e          state_q, state_d;
    logic [1:0]         sync_q, sync_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic               par_q, par_d;
    logic               ferr_q, ferr_d;
    logic               all0_q, all0_d;
    logic               push_q, push_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic               ovr_q, ovr_d;
    logic               irq_q, irq_d;

    logic               rxd;
    logic               perr;
    logic               ferr_n;
    logic               all0_n;
    logic               brk;
    logic [WORD_W-1:0]  head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop_ok;
    logic               push_ok;
    logic [FC_W-1:0]    fc_next;

    assign rxd = sync_q[1];

    always_comb begin
        perr = 1'b0;
        if (PARITY_MODE == PARITY_EVEN) begin
            perr = ^shift_q ^ par_q;
        end else if (PARITY_MODE == PARITY_ODD) begin
            perr = ~(^shift_q ^ par_q);
        end
    end

    always_comb begin
        sync_d  = {sync_q[0], dataIn};
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        ferr_d  = ferr_q;
        all0_d  = all0_q;
        push_d  = 1'b0;
        word_d  = word_q;
        ferr_n  = ferr_q | ~rxd;
        all0_n  = all0_q & ~rxd;
        brk     = (shift_q == '0) && all0_n && ((PARITY_MODE == PARITY_NONE) || !par_q);
        case (state_q)
            ST_IDLE: begin
                if (!rxd) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                // Mid-bit check rejects glitches shorter than half a bit.
                if (cnt_q == CNT_W'(OS / 2 - 1)) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rxd ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_W'(OS - 1)) begin
                    cnt_d   = '0;
                    shift_d = {rxd, shift_q[DATA_W-1:1]};
                    if (idx_q == IDX_W'(DATA_W - 1)) begin
                        idx_d   = '0;
                        ferr_d  = 1'b0;
                        all0_d  = 1'b1;
                        state_d = (PARITY_MODE == PARITY_NONE) ? ST_STOP : ST_PARITY;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PARITY: begin
                if (cnt_q == CNT_W'(OS - 1)) begin
                    cnt_d   = '0;
                    par_d   = rxd;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_W'(OS - 1)) begin
                    cnt_d  = '0;
                    ferr_d = ferr_n;
                    all0_d = all0_n;
                    if (idx_q == IDX_W'(STOP_BITS - 1)) begin
                        idx_d   = '0;
                        push_d  = 1'b1;
                        word_d  = {brk, ferr_n, perr, shift_q};
                        // A framing error may be a held-low line; wait for idle before re-arming.
                        state_d = ferr_n ? ST_WAIT_HIGH : ST_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_HIGH: begin
                if (rxd) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign pop_ok  = host_acknowledged && !fifo_empty;
    assign push_ok = push_q && (!fifo_full || pop_ok);

    always_comb begin
        ovr_d = ovr_q;
        if (host_acknowledged) begin
            ovr_d = 1'b0;
        end
        if (push_q && !push_ok) begin
            ovr_d = 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   fc_next = fifo_count + FC_W'(1);
            2'b01:   fc_next = fifo_count - FC_W'(1);
            default: fc_next = fifo_count;
        endcase
        irq_d = (fc_next != '0) || ovr_d;
    end

    always_ff @(posedge overSampler) begin
        if (!reset_n) begin
            sync_q  <= 2'b11;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            ferr_q  <= 1'b0;
            all0_q  <= 1'b0;
            push_q  <= 1'b0;
            word_q  <= '0;
            ovr_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            ferr_q  <= ferr_d;
            all0_q  <= all0_d;
            push_q  <= push_d;
            word_q  <= word_d;
            ovr_q   <= ovr_d;
            irq_q   <= irq_d;
        end
    end

    rx_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (overSampler),
        .rst_n (reset_n),
        .push  (push_q),
        .wdata (word_q),
        .pop   (host_acknowledged),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        err           = 4'b0000;
        err[ERR_OVR]  = ovr_q;
        err[ERR_PERR] = head[DATA_W];
        err[ERR_FERR] = head[DATA_W+1];
        err[ERR_BRK]  = head[DATA_W+2];
    end

    assign dataOut        = head[DATA_W-1:0];
    assign host_interrupt = irq_q;

endmodule
